// File: rtl/ball_if.sv
// rtl/ball_if.sv - ball stage handshake bundle: frame tick, paddle/VGA inputs, ball outputs
interface ball_if;
    logic       update;
    logic       serve;
    logic [9:0] paddle_x;
    logic [9:0] vgax;
    logic [8:0] vgay;
    logic       pixel;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       hit;
    logic       miss;

    modport master (
        output update, serve, paddle_x, vgax, vgay,
        input  pixel, ball_x, ball_y, hit, miss
    );

    modport slave (
        input  update, serve, paddle_x, vgax, vgay,
        output pixel, ball_x, ball_y, hit, miss
    );
endinterface

// File: rtl/ball.sv
// rtl/ball.sv - ball mover with wall/paddle bounces, hit/miss pulses and registered ball pixel
module ball #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int BALL_SIZE     = 8,
    parameter int SPEED         = 2,
    parameter int PADDLE_WIDTH  = 50,
    parameter int PADDLE_MIN_Y  = 440,
    parameter int START_X       = 316,
    parameter int START_Y       = 240,
    parameter int MISS_HOLD     = 60
) (
    input  logic clck,
    input  logic reset,
    ball_if.slave bus
);
    localparam int CW = (MISS_HOLD > 2) ? $clog2(MISS_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MISS_HOLD - 1);

    // All geometry is done in 11 bits so sums never wrap.
    localparam logic [10:0] L_W   = 11'(SCREEN_WIDTH);
    localparam logic [10:0] L_H   = 11'(SCREEN_HEIGHT);
    localparam logic [10:0] L_BS  = 11'(BALL_SIZE);
    localparam logic [10:0] L_SPD = 11'(SPEED);
    localparam logic [10:0] L_PW  = 11'(PADDLE_WIDTH);
    localparam logic [10:0] L_PY  = 11'(PADDLE_MIN_Y);

    typedef enum logic [1:0] {IDLE, PLAY, MISSED} state_t;

    state_t        state;
    logic [9:0]    bx;
    logic [8:0]    by;
    logic          dx_pos;
    logic          dy_down;
    logic [CW-1:0] hold;
    logic          pix_r, hit_r, miss_r;

    logic [10:0] x11, y11, px11, vx11, vy11;
    logic [9:0]  nx;
    logic [8:0]  ny;
    logic        ndx, ndy, bounce, bottom, crossing, overlap, on_ball;

    assign x11  = {1'b0, bx};
    assign y11  = {2'b0, by};
    assign px11 = {1'b0, bus.paddle_x};
    assign vx11 = {1'b0, bus.vgax};
    assign vy11 = {2'b0, bus.vgay};

    assign crossing = (y11 + L_BS <= L_PY) && (y11 + L_BS + L_SPD > L_PY);
    assign overlap  = (x11 + L_BS - 11'd1 >= px11) && (x11 <= px11 + L_PW);
    assign on_ball  = (state != MISSED)
                   && (vx11 >= x11) && (vx11 <= x11 + L_BS - 11'd1)
                   && (vy11 >= y11) && (vy11 <= y11 + L_BS - 11'd1);

    always_comb begin
        nx     = bx;
        ndx    = dx_pos;
        ny     = by;
        ndy    = dy_down;
        bounce = 1'b0;
        bottom = 1'b0;

        if (dx_pos) begin
            if (x11 + L_SPD + L_BS >= L_W) begin
                nx  = 10'(L_W - L_BS);
                ndx = 1'b0;
            end else begin
                nx = 10'(x11 + L_SPD);
            end
        end else if (x11 <= L_SPD) begin
            nx  = '0;
            ndx = 1'b1;
        end else begin
            nx = 10'(x11 - L_SPD);
        end

        // The paddle is only tested on the tick the ball's bottom edge crosses its top row.
        if (!dy_down) begin
            if (y11 <= L_SPD) begin
                ny  = '0;
                ndy = 1'b1;
            end else begin
                ny = 9'(y11 - L_SPD);
            end
        end else if (crossing) begin
            if (overlap) begin
                ny     = 9'(L_PY - L_BS);
                ndy    = 1'b0;
                bounce = 1'b1;
            end else begin
                ny = 9'(y11 + L_SPD);
            end
        end else if (y11 + L_BS + L_SPD >= L_H) begin
            ny     = 9'(L_H - L_BS);
            bottom = 1'b1;
        end else begin
            ny = 9'(y11 + L_SPD);
        end
    end

    always_ff @(posedge clck or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bx      <= 10'(START_X);
            by      <= 9'(START_Y);
            dx_pos  <= 1'b1;
            dy_down <= 1'b0;
            hold    <= '0;
            pix_r   <= 1'b0;
            hit_r   <= 1'b0;
            miss_r  <= 1'b0;
        end else begin
            hit_r  <= 1'b0;
            miss_r <= 1'b0;
            pix_r  <= on_ball;
            if (bus.update) begin
                case (state)
                    IDLE: begin
                        if (bus.serve) begin
                            state   <= PLAY;
                            dx_pos  <= 1'b1;
                            dy_down <= 1'b0;
                        end
                    end
                    PLAY: begin
                        bx      <= nx;
                        by      <= ny;
                        dx_pos  <= ndx;
                        dy_down <= ndy;
                        hit_r   <= bounce;
                        if (bottom) begin
                            miss_r <= 1'b1;
                            state  <= MISSED;
                        end
                    end
                    MISSED: begin
                        if (hold == HOLD_LAST) begin
                            state   <= IDLE;
                            bx      <= 10'(START_X);
                            by      <= 9'(START_Y);
                            dx_pos  <= 1'b1;
                            dy_down <= 1'b0;
                            hold    <= '0;
                        end else begin
                            hold <= hold + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.pixel  = pix_r;
    assign bus.ball_x = bx;
    assign bus.ball_y = by;
    assign bus.hit    = hit_r;
    assign bus.miss   = miss_r;
endmodule

// File: tb/tb_ball.sv
// tb/tb_ball.sv - self-checking bench for ball: pixel table, directed serve/miss/reset, randomized play vs model
module tb_ball;
    logic clck = 1'b0;
    logic reset;
    ball_if bus();

    ball dut (.clck(clck), .reset(reset), .bus(bus));

    always #5 clck = ~clck;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: position plus signed velocity, mode 0=idle 1=play 2=missed.
    int m_mode, m_x, m_y, m_vx, m_vy, m_hold, m_pix, m_hit, m_miss;
    int n_hits = 0, n_miss = 0;

    typedef struct {
        logic [9:0] vx;
        logic [8:0] vy;
        logic       exp;
    } pix_vec_t;
    pix_vec_t pv[12];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_x = 316; m_y = 240; m_vx = 2; m_vy = -2;
        m_hold = 0; m_pix = 0; m_hit = 0; m_miss = 0;
    endfunction

    function automatic void model_edge(input int u, input int s, input int px, input int vx, input int vy);
        int ox, nx, ny;
        m_pix  = (m_mode != 2 && vx >= m_x && vx < m_x + 8 && vy >= m_y && vy < m_y + 8) ? 1 : 0;
        m_hit  = 0;
        m_miss = 0;
        if (u == 0) return;
        if (m_mode == 0) begin
            if (s != 0) begin m_mode = 1; m_vx = 2; m_vy = -2; end
        end else if (m_mode == 1) begin
            ox = m_x;
            nx = m_x + m_vx;
            if (nx >= 632)   begin m_x = 632; m_vx = -m_vx; end
            else if (nx <= 0) begin m_x = 0;   m_vx = -m_vx; end
            else m_x = nx;
            ny = m_y + m_vy;
            if (m_vy < 0) begin
                if (ny <= 0) begin m_y = 0; m_vy = -m_vy; end
                else m_y = ny;
            end else if (m_y + 8 <= 440 && ny + 8 > 440) begin
                if (ox + 7 >= px && ox <= px + 50) begin
                    m_y = 432; m_vy = -m_vy; m_hit = 1; n_hits++;
                end else m_y = ny;
            end else if (ny >= 472) begin
                m_y = 472; m_miss = 1; m_mode = 2; n_miss++;
            end else m_y = ny;
        end else begin
            m_hold++;
            if (m_hold == 60) begin
                m_mode = 0; m_x = 316; m_y = 240; m_vx = 2; m_vy = -2; m_hold = 0;
            end
        end
    endfunction

    task automatic cmp_all(input string tag);
        chk({tag, ".ball_x"}, int'(bus.ball_x), m_x);
        chk({tag, ".ball_y"}, int'(bus.ball_y), m_y);
        chk({tag, ".pixel"},  int'(bus.pixel),  m_pix);
        chk({tag, ".hit"},    int'(bus.hit),    m_hit);
        chk({tag, ".miss"},   int'(bus.miss),   m_miss);
    endtask

    task automatic tick(input string tag, input int u, input int s, input int px, input int vx, input int vy);
        bus.update   = u[0];
        bus.serve    = s[0];
        bus.paddle_x = 10'(px);
        bus.vgax     = 10'(vx);
        bus.vgay     = 9'(vy);
        @(posedge clck);
        #1;
        model_edge(u, s, px, vx, vy);
        cmp_all(tag);
    endtask

    function automatic int near(input int base, input int hi);
        int v;
        v = base + int'($urandom_range(0, 11)) - 2;
        if (v < 0) v = 0;
        if (v > hi) v = hi;
        return v;
    endfunction

    initial begin
        pv[0]  = '{10'd316, 9'd240, 1'b1};
        pv[1]  = '{10'd315, 9'd240, 1'b0};
        pv[2]  = '{10'd323, 9'd240, 1'b1};
        pv[3]  = '{10'd324, 9'd240, 1'b0};
        pv[4]  = '{10'd316, 9'd239, 1'b0};
        pv[5]  = '{10'd316, 9'd247, 1'b1};
        pv[6]  = '{10'd316, 9'd248, 1'b0};
        pv[7]  = '{10'd323, 9'd247, 1'b1};
        pv[8]  = '{10'd320, 9'd244, 1'b1};
        pv[9]  = '{10'd0,   9'd0,   1'b0};
        pv[10] = '{10'd324, 9'd248, 1'b0};
        pv[11] = '{10'd319, 9'd243, 1'b1};

        reset = 1'b1;
        bus.update = 1'b0; bus.serve = 1'b0; bus.paddle_x = '0; bus.vgax = '0; bus.vgay = '0;
        model_reset();
        repeat (2) @(posedge clck);
        #1;
        chk("rst.ball_x", int'(bus.ball_x), 316);
        chk("rst.ball_y", int'(bus.ball_y), 240);
        chk("rst.pixel",  int'(bus.pixel), 0);
        chk("rst.hit",    int'(bus.hit), 0);
        chk("rst.miss",   int'(bus.miss), 0);
        reset = 1'b0;

        // Pixel window at the serve position; pixel lands one edge after vga.
        foreach (pv[i]) begin
            tick("ptab", 0, 0, 0, int'(pv[i].vx), int'(pv[i].vy));
            chk("ptab.pixel", int'(bus.pixel), int'(pv[i].exp));
        end

        for (int i = 0; i < 5; i++) begin
            tick("idle", 1, 0, 100, 320, 244);
            chk("idle.x", int'(bus.ball_x), 316);
            chk("idle.y", int'(bus.ball_y), 240);
        end

        tick("serve", 1, 1, 100, 0, 0);
        chk("serve.x", int'(bus.ball_x), 316);
        chk("serve.y", int'(bus.ball_y), 240);
        tick("first", 1, 0, 100, 0, 0);
        chk("first.x", int'(bus.ball_x), 318);
        chk("first.y", int'(bus.ball_y), 238);

        // Random play: paddle usually tracks the ball so both hits and misses occur.
        for (int i = 0; i < 6000; i++) begin
            int px;
            if ($urandom_range(0, 3) == 0) px = int'($urandom_range(0, 589));
            else begin
                px = m_x - int'($urandom_range(0, 40));
                if (px < 0) px = 0;
            end
            tick("rand", int'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 1 : 0,
                 px, near(m_x, 639), near(m_y, 479));
        end

        // Forced miss: paddle kept on the far side of the ball.
        for (int i = 0; i < 3000 && m_mode != 2; i++)
            tick("tomiss", 1, 1, (m_x < 320) ? 589 : 0, m_x, m_y);
        chk("miss.reached", m_mode, 2);
        chk("miss.y", int'(bus.ball_y), 472);
        for (int i = 0; i < 59; i++)
            tick("hold", 1, 0, 0, m_x + 1, m_y + 1);
        chk("hold.y", int'(bus.ball_y), 472);
        chk("hold.pixel", int'(bus.pixel), 0);
        tick("rearm", 1, 0, 0, 0, 0);
        chk("rearm.x", int'(bus.ball_x), 316);
        chk("rearm.y", int'(bus.ball_y), 240);
        tick("rearm.pix", 0, 0, 0, 317, 241);
        chk("rearm.pixel", int'(bus.pixel), 1);

        // Asynchronous reset between edges, mid-play.
        tick("arst.serve", 1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) tick("arst.play", 1, 0, 0, m_x, m_y);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.x", int'(bus.ball_x), 316);
        chk("arst.y", int'(bus.ball_y), 240);
        chk("arst.pixel", int'(bus.pixel), 0);
        chk("arst.hit", int'(bus.hit), 0);
        chk("arst.miss", int'(bus.miss), 0);
        model_reset();
        @(posedge clck);
        #1;
        reset = 1'b0;
        tick("post.serve", 1, 1, 0, 0, 0);
        tick("post.first", 1, 0, 0, 0, 0);
        chk("post.x", int'(bus.ball_x), 318);
        chk("post.y", int'(bus.ball_y), 238);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ball.md
Name: ball

Overview:
- Game-ball stage directly downstream of the paddle: consumes the paddle's registered x position, moves a square ball once per frame tick, and bounces it off the walls and the paddle.
- Reports paddle hits and misses to score/lives logic.
- Produces a registered ball pixel for the VGA mixer, alongside the paddle pixel.
- Screen is 640x480; the paddle occupies rows 440..460.

Parameters:
- SCREEN_WIDTH, 640, visible columns
- SCREEN_HEIGHT, 480, visible rows
- BALL_SIZE, 8, ball edge length in pixels
- SPEED, 2, pixels moved per axis per frame tick
- PADDLE_WIDTH, 50, paddle span; the paddle covers columns paddle_x..paddle_x+PADDLE_WIDTH inclusive
- PADDLE_MIN_Y, 440, top row of the paddle
- START_X, 316, serve position (top-left x)
- START_Y, 240, serve position (top-left y)
- MISS_HOLD, 60, frame ticks spent in MISSED before re-arming

Ports:
- clck  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- update  in  1  one-clck-wide frame tick, synchronous to clck
- serve  in  1  launch request, level-sampled on update cycles
- paddle_x  in  10  paddle left column from the paddle stage
- vgax  in  10  current VGA column
- vgay  in  9  current VGA row
- pixel  out  1  registered ball pixel
- ball_x  out  10  ball top-left column
- ball_y  out  9  ball top-left row
- hit  out  1  one-clck pulse on a paddle bounce
- miss  out  1  one-clck pulse when the ball reaches the bottom

Behaviour:
- Reset values: state IDLE, ball_x=START_X, ball_y=START_Y, dx=+1, dy=-1 (up), hold counter 0, pixel=0, hit=0, miss=0.
- Reset is asynchronous: outputs take their reset values immediately, with no clck edge needed, including mid-PLAY or mid-MISSED.
- State machine; all transitions occur only on clck edges with update=1:
  - IDLE: ball parked at start. serve=1 → PLAY with dx=+1, dy=-1. Position does not change on the transition tick.
  - PLAY: move as described below. serve is ignored.
  - MISSED: counter increments each tick. When the counter reaches MISS_HOLD-1 → IDLE, position restored to start, dx=+1, dy=-1, counter cleared.
- PLAY motion per tick: X and Y are evaluated independently in the same tick, so corner bounces flip both directions at once.
  - X, dx=+1: if ball_x+SPEED+BALL_SIZE >= SCREEN_WIDTH then ball_x=SCREEN_WIDTH-BALL_SIZE and dx=-1; else ball_x+=SPEED.
  - X, dx=-1: if ball_x <= SPEED then ball_x=0 and dx=+1; else ball_x-=SPEED.
  - Y, dy=-1: if ball_y <= SPEED then ball_y=0 and dy=+1; else ball_y-=SPEED.
  - Y, dy=+1, paddle crossing: a crossing is ball_y+BALL_SIZE <= PADDLE_MIN_Y and ball_y+BALL_SIZE+SPEED > PADDLE_MIN_Y.
    - On a crossing with overlap (ball_x+BALL_SIZE-1 >= paddle_x and ball_x <= paddle_x+PADDLE_WIDTH): ball_y=PADDLE_MIN_Y-BALL_SIZE, dy=-1, hit=1 for one clck.
    - The overlap test uses ball_x before this tick's X update.
    - On a crossing without overlap: ball_y+=SPEED.
  - Y, dy=+1, otherwise: if ball_y+BALL_SIZE+SPEED >= SCREEN_HEIGHT then ball_y=SCREEN_HEIGHT-BALL_SIZE, miss=1 for one clck, state → MISSED. Else ball_y+=SPEED.
  - A ball already below the paddle top is never rescued, even if the paddle moves under it.
- Arithmetic: all comparisons use 11-bit unsigned zero-extended operands, so there is no wrap-around. Stored positions never leave 0..SCREEN-BALL_SIZE.
- hit and miss are cleared on every clck edge where they are not being set.
- Pixel:
  - Registered every clck edge: pixel = (state != MISSED) and ball_x <= vgax <= ball_x+BALL_SIZE-1 and ball_y <= vgay <= ball_y+BALL_SIZE-1.
  - Latency is one clck from vgax/vgay.
  - Uses ball_x/ball_y as held before that edge.
- update=0 cycles change nothing except pixel, hit and miss.

Test Plan:
- Reset, then 5 update ticks with serve=0 → ball_x=316, ball_y=240 throughout; pixel=1 exactly when vgax=316..323 and vgay=240..247, one clck late.
- serve=1 on one tick, then one more tick → first tick leaves (316,240); second gives (318,238).
- Ball at ball_x=630, dx=+1, tick → ball_x=632, dx=-1; next tick → ball_x=630. Ball at ball_x=1, dx=-1 → ball_x=0, dx=+1.
- Ball at (120,431), dy=+1, dx=+1, paddle_x=100, tick → ball_y=432, dy=-1, ball_x=122, hit high for exactly one clck.
- Ball at (120,431), dy=+1, paddle_x=300: ticks → ball_y=433, 435, … then 472 with one miss pulse; pixel stays 0 in MISSED; after 60 further ticks → IDLE at (316,240), pixel visible again.
- Assert reset asynchronously mid-PLAY between clck edges → ball_x=316, ball_y=240, pixel=0, hit=0, miss=0 before the next clck edge; following serve works normally.
